// File: rtl/decode_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_arbiter_if
//  Description : Instruction-buffer request/pop bundle plus the decode-to-issue
//                valid/ready channel of the per-warp issue arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface decode_issue_arbiter_if #(
    parameter int NUM_WARPS = 4,
    parameter int DATAW     = 128,
    parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
    logic [NUM_WARPS-1:0]       in_valid;
    logic [NUM_WARPS-1:0]       in_stall;
    logic [NUM_WARPS*DATAW-1:0] in_data;
    logic [NUM_WARPS-1:0]       ibuf_pop;
    logic                       out_valid;
    logic [NW_BITS-1:0]         out_wid;
    logic [DATAW-1:0]           out_data;
    logic                       out_ready;

    // master: instruction buffers plus downstream consumer; slave: the arbiter
    modport master (
        output in_valid, in_stall, in_data, out_ready,
        input  ibuf_pop, out_valid, out_wid, out_data
    );

    modport slave (
        input  in_valid, in_stall, in_data, out_ready,
        output ibuf_pop, out_valid, out_wid, out_data
    );
endinterface
`default_nettype wire

// File: rtl/decode_issue_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_arbiter
//  Description : Round-robin per-warp issue arbiter with starvation override,
//                feeding a one-entry decode output register.
//  Revision    : 1.0  initial release
// ============================================================================
module decode_issue_arbiter #(
    parameter int NUM_WARPS    = 4,
    parameter int DATAW        = 128,
    parameter int STARVE_LIMIT = 15,
    parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    decode_issue_arbiter_if.slave       bus
);
    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
    localparam logic [NW_BITS:0]   c_NW    = (NW_BITS + 1)'(NUM_WARPS);
    localparam logic [NW_BITS-1:0] c_LAST  = NW_BITS'(NUM_WARPS - 1);

    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_starved;
    logic [NUM_WARPS-1:0] w_pop;
    logic                 w_load;
    logic                 w_any_starved;
    logic [NW_BITS-1:0]   w_grant;
    logic [NW_BITS-1:0]   w_rr_grant;
    logic [NW_BITS-1:0]   w_starve_grant;
    logic [NW_BITS-1:0]   w_rr_next;

    logic [NW_BITS-1:0]   r_rr_ptr;
    logic                 r_out_valid;
    logic [NW_BITS-1:0]   r_out_wid;
    logic [DATAW-1:0]     r_out_data;

    assign w_elig = bus.in_valid & ~bus.in_stall;
    assign w_load = (~r_out_valid | bus.out_ready) & (|w_elig);

    // Descending scan so the lowest starved index is the one left standing.
    always_comb begin
        w_starve_grant = '0;
        for (int w = NUM_WARPS - 1; w >= 0; w--) begin
            if (w_starved[w]) begin
                w_starve_grant = NW_BITS'(w);
            end
        end
    end

    assign w_any_starved = |w_starved;

    // Scan offsets from far to near so the warp closest to rr_ptr wins.
    always_comb begin
        logic [NW_BITS:0] v_idx;
        v_idx      = '0;
        w_rr_grant = r_rr_ptr;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            v_idx = {1'b0, r_rr_ptr} + (NW_BITS + 1)'(i);
            if (v_idx >= c_NW) begin
                v_idx = v_idx - c_NW;
            end
            if (w_elig[v_idx[NW_BITS-1:0]]) begin
                w_rr_grant = v_idx[NW_BITS-1:0];
            end
        end
    end

    assign w_grant   = w_any_starved ? w_starve_grant : w_rr_grant;
    assign w_rr_next = (w_grant == c_LAST) ? '0 : w_grant + 1'b1;

    always_comb begin
        w_pop = '0;
        if (w_load && !reset) begin
            w_pop[w_grant] = 1'b1;
        end
    end

    assign bus.ibuf_pop = w_pop;

    // Wait counters also advance while the output is blocked, so a warp held
    // back by backpressure can still reach the starvation limit.
    generate
        for (genvar w = 0; w < NUM_WARPS; w++) begin : g_wait
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!w_elig[w] || (w_load && (w_grant == NW_BITS'(w)))) begin
                    r_cnt <= '0;
                end else if (r_cnt != c_LIMIT) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_starved[w] = w_elig[w] & (r_cnt == c_LIMIT);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_wid   <= '0;
            r_out_data  <= '0;
        end else if (w_load) begin
            r_rr_ptr    <= w_rr_next;
            r_out_valid <= 1'b1;
            r_out_wid   <= w_grant;
            r_out_data  <= bus.in_data[w_grant*DATAW +: DATAW];
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_wid   = r_out_wid;
    assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire
